// File: rtl/adc_pkg.sv
// Shared widths, FSM state encoding and decoder result type for the
// thermometer-code ADC conversion controller.
package adc_pkg;
    localparam int THERM_W = 15;
    localparam int CODE_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] val;
        logic              bubble;
    } therm_dec_t;
endpackage

// File: rtl/adc_therm2bin.sv
// Thermometer-to-binary decoder: value is the zero count, bubble flags any
// one bit sitting directly below a zero bit.
module adc_therm2bin
    import adc_pkg::*;
(
    input  logic [THERM_W-1:0] y,
    output therm_dec_t         dec
);

    logic [CODE_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < THERM_W; i++)
            ones = ones + CODE_W'(y[i]);
        dec.val    = CODE_W'(THERM_W) - ones;
        dec.bubble = |(y[THERM_W-2:0] & ~y[THERM_W-1:1]);
    end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer: strobe, settle, sample repeated 2^AVG_LOG2 times,
// then a rounded average is held until the consumer accepts it.
module adc_conv_ctrl
    import adc_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [THERM_W-1:0] Y,
    output logic               comp_en,
    output logic               busy,
    output logic [CODE_W-1:0]  code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_err,
    output logic [7:0]         err_cnt
);

    localparam int ACC_W = CODE_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);
    // Half an LSB of the averaged result; zero when no averaging is done.
    localparam logic [ACC_W:0]   HALF = (ACC_W + 1)'((1 << AVG_LOG2) >> 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_nxt;
    logic [CNT_W-1:0] smp_cnt;
    logic [3:0]       set_cnt;
    logic             conv_err;
    therm_dec_t       dec;

    adc_therm2bin u_dec (
        .y   (Y),
        .dec (dec)
    );

    assign sum_nxt = acc + ACC_W'(dec.val);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            comp_en   <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            code      <= '0;
            err_cnt   <= '0;
            acc       <= '0;
            smp_cnt   <= '0;
            set_cnt   <= '0;
            conv_err  <= 1'b0;
        end else begin
            comp_en <= 1'b0;
            // Abort beats every other transition, including the DONE handshake.
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state    <= S_STROBE;
                            comp_en  <= 1'b1;
                            acc      <= '0;
                            smp_cnt  <= '0;
                            conv_err <= 1'b0;
                        end
                    end
                    S_STROBE: begin
                        set_cnt <= '0;
                        state   <= (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (set_cnt == 4'(SETTLE_CYC - 1))
                            state <= S_SAMPLE;
                        else
                            set_cnt <= set_cnt + 4'd1;
                    end
                    S_SAMPLE: begin
                        acc <= sum_nxt;
                        if (dec.bubble) begin
                            conv_err <= 1'b1;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end
                        if (smp_cnt == LAST) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            code      <= CODE_W'(({1'b0, sum_nxt} + HALF) >> AVG_LOG2);
                            out_err   <= conv_err | dec.bubble;
                        end else begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                            state   <= S_STROBE;
                            comp_en <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed bench for adc_conv_ctrl: a vector table of 4-sample conversions
// plus hand-written handshake, abort, saturation and reset sequences.
module tb_adc_conv_ctrl;

    typedef logic [3:0][14:0] ys_t;
    typedef struct {
        ys_t        ys;
        logic [3:0] code;
        logic       err;
        int         nbub;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, out_ready;
    logic [14:0] Y;
    logic        comp_en, busy, out_valid, out_err;
    logic [3:0]  code;
    logic [7:0]  err_cnt;

    logic        rst0, start0, abort0, out_ready0;
    logic [14:0] Y0;
    logic        comp_en0, busy0, out_valid0, out_err0;
    logic [3:0]  code0;
    logic [7:0]  err_cnt0;

    adc_conv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .Y(Y),
        .comp_en(comp_en), .busy(busy), .code(code), .out_valid(out_valid),
        .out_ready(out_ready), .out_err(out_err), .err_cnt(err_cnt)
    );

    adc_conv_ctrl #(.SETTLE_CYC(0), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .abort(abort0), .Y(Y0),
        .comp_en(comp_en0), .busy(busy0), .code(code0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_err(out_err0), .err_cnt(err_cnt0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] y_of(input int v);
        logic [14:0] f;
        f = 15'h7FFF;
        return f << v;
    endfunction

    function automatic ys_t mk(input logic [14:0] a, b, c, d);
        ys_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Start a default-parameter conversion and run until out_valid (bounded).
    task automatic conv(input ys_t ys, output int lat, output logic [15:0] cpat);
        lat  = 0;
        cpat = '0;
        Y    = ys[0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c % 4 == 1 && c <= 13) Y = ys[(c - 1) / 4];
            if (comp_en && c < 16) cpat[c] = 1'b1;
            if (out_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) chk("conv_timeout", 0, 1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic conv0(input logic [14:0] y, output int lat);
        lat = 0;
        Y0  = y;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid0) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) chk("conv0_timeout", 0, 1);
    endtask

    vec_t        vt[10];
    int          lat;
    logic [15:0] cpat;
    int          exp_ec;
    logic        seen;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; Y = 15'h7FFF;
        rst0 = 1'b1; start0 = 1'b0; abort0 = 1'b0; out_ready0 = 1'b0; Y0 = 15'h7FFF;

        vt[0] = '{mk(15'h7FF0, 15'h7FF0, 15'h7FF0, 15'h7FF0), 4'd4,  1'b0, 0};
        vt[1] = '{mk(y_of(3), y_of(3), y_of(4), y_of(4)),     4'd4,  1'b0, 0};
        vt[2] = '{mk(y_of(3), y_of(3), y_of(3), y_of(4)),     4'd3,  1'b0, 0};
        vt[3] = '{mk(15'h0000, 15'h0000, 15'h0000, 15'h0000), 4'd15, 1'b0, 0};
        vt[4] = '{mk(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF), 4'd0,  1'b0, 0};
        vt[5] = '{mk(15'h7FF0, 15'h7FF5, 15'h7FF0, 15'h7FF0), 4'd4,  1'b1, 1};
        vt[6] = '{mk(y_of(1), y_of(2), y_of(0), y_of(2)),     4'd1,  1'b0, 0};
        vt[7] = '{mk(y_of(15), y_of(15), y_of(15), y_of(14)), 4'd15, 1'b0, 0};
        vt[8] = '{mk(15'h7FF5, 15'h7FF5, 15'h7FF5, 15'h7FF5), 4'd2,  1'b1, 4};
        vt[9] = '{mk(15'h0001, 15'h0000, 15'h0000, 15'h0000), 4'd15, 1'b1, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_comp_en", comp_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_code", code, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0; rst0 = 1'b0;

        exp_ec = 0;
        foreach (vt[i]) begin
            conv(vt[i].ys, lat, cpat);
            exp_ec += vt[i].nbub;
            chk($sformatf("v%0d_latency", i), lat, 17);
            chk($sformatf("v%0d_comp_en_cycles", i), cpat, 16'h2222);
            chk($sformatf("v%0d_code", i), code, vt[i].code);
            chk($sformatf("v%0d_out_err", i), out_err, vt[i].err);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, exp_ec);
            accept();
            chk($sformatf("v%0d_idle_after_accept", i), {busy, out_valid}, 0);
        end

        // Backpressure: result held, start pulses ignored, no queued start.
        conv(mk(15'h7FF0, 15'h7FF0, 15'h7FF0, 15'h7FF0), lat, cpat);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            @(negedge clk);
            if (!(out_valid && busy && code == 4'd4 && !out_err)) seen = 1'b1;
        end
        start = 1'b0;
        chk("hold_stable", seen, 0);
        accept();
        chk("hold_idle_after_accept", busy, 0);
        repeat (3) @(negedge clk);
        chk("hold_no_queued_start", busy, 0);

        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("ready_while_idle", {busy, out_valid}, 0);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, comp_en}, 0);

        // Abort in SETTLE of the second sample.
        Y = 15'h7FF0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, out_valid, comp_en}, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (comp_en || out_valid || busy) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        conv(mk(15'h7FF0, 15'h7FF0, 15'h7FF0, 15'h7FF0), lat, cpat);
        chk("abort_restart_latency", lat, 17);
        chk("abort_restart_code", code, 4);
        // Abort together with out_ready in DONE discards the result.
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_done", {busy, out_valid}, 0);
        chk("abort_done_err_cnt", err_cnt, exp_ec);

        // 256 further bubble samples saturate the counter.
        for (int k = 0; k < 64; k++) begin
            conv(mk(15'h7FF5, 15'h7FF5, 15'h7FF5, 15'h7FF5), lat, cpat);
            accept();
        end
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_out_err", out_err, 1);

        // Reset during SAMPLE.
        Y = 15'h7FF0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sample_outs", {busy, comp_en, out_valid, out_err, code, err_cnt}, 0);

        // Reset during DONE.
        conv(mk(15'h7FF5, 15'h7FF5, 15'h7FF5, 15'h7FF5), lat, cpat);
        chk("pre_rst_done_err_cnt", err_cnt, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_outs", {busy, comp_en, out_valid, out_err, code, err_cnt}, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("rst_no_valid_after", seen, 0);

        // No averaging, no settle time.
        conv0(15'h0000, lat);
        chk("d0_latency", lat, 3);
        chk("d0_code", code0, 15);
        chk("d0_out_err", out_err0, 0);
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        chk("d0_idle", busy0, 0);
        conv0(15'h7FF5, lat);
        chk("d0_bubble_code", code0, 2);
        chk("d0_bubble_err", {out_err0, err_cnt0}, {1'b1, 8'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
